// File: rtl/fpdiv_ctrl.sv
// rtl/fpdiv_ctrl.sv - Goldschmidt divider sequencing FSM (Moore outputs).
// Optional remainder-product state is built in only when FPDIV_CTRL_REM_EN is defined.
module fpdiv_ctrl #(
  parameter int unsigned ITER = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       en_a,
  output logic       en_b,
  output logic       en_rem,
  output logic [1:0] sel_mux3,
  output logic [1:0] sel_mux4,
  output logic       busy,
  output logic       done,
  output logic [2:0] iter_cnt
);

  localparam logic [3:0] ITER_W = 4'(ITER);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_INIT_A = 3'd1,
    S_INIT_B = 3'd2,
    S_ITER_A = 3'd3,
    S_ITER_B = 3'd4,
`ifdef FPDIV_CTRL_REM_EN
    S_REM    = 3'd5,
`endif
    S_DONE   = 3'd6
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] iter_cnt_q, iter_cnt_d;
  logic [3:0] iter_inc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      iter_cnt_q <= 3'd0;
    end else begin
      state_q    <= state_d;
      iter_cnt_q <= iter_cnt_d;
    end
  end

  assign iter_inc = {1'b0, iter_cnt_q} + 4'd1;
  assign iter_cnt = iter_cnt_q;

  always_comb begin
    state_d    = state_q;
    iter_cnt_d = iter_cnt_q;
    en_a       = 1'b0;
    en_b       = 1'b0;
    en_rem     = 1'b0;
    sel_mux3   = 2'd0;
    sel_mux4   = 2'd0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_INIT_A;
      end
      S_INIT_A: begin
        en_a    = 1'b1;
        busy    = 1'b1;
        state_d = S_INIT_B;
      end
      S_INIT_B: begin
        en_b       = 1'b1;
        sel_mux4   = 2'd1;
        busy       = 1'b1;
        iter_cnt_d = 3'd0;
        state_d    = S_ITER_A;
      end
      // A and B refine in separate cycles so both consume the same C.
      S_ITER_A: begin
        en_a     = 1'b1;
        sel_mux3 = 2'd1;
        sel_mux4 = 2'd2;
        busy     = 1'b1;
        state_d  = S_ITER_B;
      end
      S_ITER_B: begin
        en_b       = 1'b1;
        sel_mux3   = 2'd1;
        sel_mux4   = 2'd3;
        busy       = 1'b1;
        iter_cnt_d = iter_inc[2:0];
        if (iter_inc < ITER_W) state_d = S_ITER_A;
`ifdef FPDIV_CTRL_REM_EN
        else state_d = S_REM;
`else
        else state_d = S_DONE;
`endif
      end
`ifdef FPDIV_CTRL_REM_EN
      S_REM: begin
        en_rem   = 1'b1;
        sel_mux3 = 2'd2;
        sel_mux4 = 2'd2;
        busy     = 1'b1;
        state_d  = S_DONE;
      end
`endif
      S_DONE: begin
        done    = 1'b1;
        state_d = start ? S_INIT_A : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fpdiv_ctrl.sv
// tb/tb_fpdiv_ctrl.sv - directed-vector bench for fpdiv_ctrl (ITER=3 and ITER=1 instances).
module tb_fpdiv_ctrl;

`ifdef FPDIV_CTRL_REM_EN
  localparam int REM_ON = 1;
`else
  localparam int REM_ON = 0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       start1;
  logic       en_a, en_b, en_rem, busy, done;
  logic [1:0] sel_mux3, sel_mux4;
  logic [2:0] iter_cnt;
  logic       en_a1, en_b1, en_rem1, busy1, done1;
  logic [1:0] sel_mux31, sel_mux41;
  logic [2:0] iter_cnt1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fpdiv_ctrl #(.ITER(3)) dut (
    .clk(clk), .reset(reset), .start(start),
    .en_a(en_a), .en_b(en_b), .en_rem(en_rem),
    .sel_mux3(sel_mux3), .sel_mux4(sel_mux4),
    .busy(busy), .done(done), .iter_cnt(iter_cnt)
  );

  fpdiv_ctrl #(.ITER(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1),
    .en_a(en_a1), .en_b(en_b1), .en_rem(en_rem1),
    .sel_mux3(sel_mux31), .sel_mux4(sel_mux41),
    .busy(busy1), .done(done1), .iter_cnt(iter_cnt1)
  );

  wire [8:0] v0 = {en_a, en_b, en_rem, sel_mux3, sel_mux4, busy, done};
  wire [8:0] v1 = {en_a1, en_b1, en_rem1, sel_mux31, sel_mux41, busy1, done1};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // {en_a,en_b,en_rem,sel_mux3,sel_mux4,busy,done} per phase
  // 0 IDLE 1 INIT_A 2 INIT_B 3 ITER_A 4 ITER_B 5 REM 6 DONE
  function automatic logic [8:0] exp_vec(input int ph);
    case (ph)
      1:       return 9'b1_0_0_00_00_1_0;
      2:       return 9'b0_1_0_00_01_1_0;
      3:       return 9'b1_0_0_01_10_1_0;
      4:       return 9'b0_1_0_01_11_1_0;
      5:       return 9'b0_0_1_10_10_1_0;
      6:       return 9'b0_0_0_00_00_0_1;
      default: return 9'b0_0_0_00_00_0_0;
    endcase
  endfunction

  // Called at the negedge just after the start edge; walks the ITER=3 run.
  task automatic run_full(input string tag, input logic [2:0] ic0, input bit pulse_mid);
    int         ph[$];
    logic [2:0] ic[$];
    int         done_at;
    int         n_done;
    ph = {1, 2};
    ic = {ic0, ic0};
    for (int i = 0; i < 3; i++) begin
      ph.push_back(3); ic.push_back(3'(i));
      ph.push_back(4); ic.push_back(3'(i));
    end
    if (REM_ON != 0) begin
      ph.push_back(5); ic.push_back(3'd3);
    end
    ph.push_back(6); ic.push_back(3'd3);
    ph.push_back(0); ic.push_back(3'd3);
    ph.push_back(0); ic.push_back(3'd3);
    done_at = -1;
    n_done  = 0;
    for (int k = 0; k < ph.size(); k++) begin
      chk($sformatf("%s_out%0d", tag, k), 32'(v0), 32'(exp_vec(ph[k])));
      chk($sformatf("%s_cnt%0d", tag, k), 32'(iter_cnt), 32'(ic[k]));
      chk($sformatf("%s_excl%0d", tag, k), 32'($onehot0({en_a, en_b, en_rem})), 32'd1);
      if (done) begin
        n_done++;
        if (done_at < 0) done_at = k + 1;
      end
      start = (pulse_mid && (k == 3 || k == 5)) ? 1'b1 : 1'b0;
      @(negedge clk);
    end
    chk($sformatf("%s_latency", tag), 32'(done_at), 32'(3 + REM_ON + 2 * 3));
    chk($sformatf("%s_ndone", tag), 32'(n_done), 32'd1);
  endtask

  initial begin
    int p1[$];
    int per;
    int n_done1;
    reset  = 1'b1;
    start  = 1'b0;
    start1 = 1'b0;
    #1;
    chk("rst_async_out", 32'(v0), 32'd0);
    repeat (2) @(negedge clk);
    chk("rst_out", 32'(v0), 32'd0);
    chk("rst_cnt", 32'(iter_cnt), 32'd0);
    chk("rst_out1", 32'(v1), 32'd0);
    chk("rst_cnt1", 32'(iter_cnt1), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_out", 32'(v0), 32'd0);

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    run_full("run1", 3'd0, 1'b1);

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_rst_out", 32'(v0), 32'(exp_vec(3)));
    chk("pre_rst_cnt", 32'(iter_cnt), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_out", 32'(v0), 32'd0);
    chk("mid_rst_cnt", 32'(iter_cnt), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("rst_hold_out%0d", i), 32'(v0), 32'd0);
    end
    start = 1'b1;
    reset = 1'b0;
    @(negedge clk);
    start = 1'b0;
    run_full("run2", 3'd0, 1'b0);

    // ITER=1 with start held high: back-to-back sequences, never in IDLE.
    p1 = {1, 2, 3, 4};
    if (REM_ON != 0) p1.push_back(5);
    p1.push_back(6);
    per = p1.size();
    n_done1 = 0;
    start1 = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3 * per; k++) begin
      chk($sformatf("b2b_out%0d", k), 32'(v1), 32'(exp_vec(p1[k % per])));
      chk($sformatf("b2b_excl%0d", k), 32'($onehot0({en_a1, en_b1, en_rem1})), 32'd1);
      if (p1[k % per] == 6) chk($sformatf("b2b_cnt%0d", k), 32'(iter_cnt1), 32'd1);
      if (done1) n_done1++;
      @(negedge clk);
    end
    chk("b2b_ndone", 32'(n_done1), 32'd3);
    start1 = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
